conv_pipe_mac: RTL and testbench
================================

// Module: conv_pipe_mac
// PURPOSE
//  Parametrised, pipelined 1-D valid convolution of an X vector with an F filter.
//  - Loads X and F over valid/ready streams; all F_SIZE products are evaluated in parallel.
//  - Issues one output index per cycle through a 2-stage MAC pipeline with full output back-pressure.
//  - Successor to the fixed 8x4 convolver. Sits between the X/F stream masters and the Y consumer.
// PARAMETERS
//  DATA_WIDTH_X  8   X sample width, signed
//  DATA_WIDTH_F  8   F coefficient width, signed
//  X_SIZE        8   X vector length (>= F_SIZE)
//  F_SIZE        4   filter taps (>= 1)
//  ACC_SIZE      18  output width, signed
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        synchronous, active-high
//  s_valid_x     in   1        X sample valid
//  s_ready_x     out  1        X sample accepted when valid & ready
//  s_data_in_x   in   DWX      X sample
//  s_valid_f     in   1        F coefficient valid
//  s_ready_f     out  1        F coefficient accepted when valid & ready
//  s_data_in_f   in   DWF      F coefficient
//  m_valid_y     out  1        Y output valid
//  m_ready_y     in   1        Y consumer ready
//  m_data_out_y  out  ACC_SIZE y[k] = sum_{j<F_SIZE} x[k+j]*f[j]
//  m_last_y      out  1        high with the final y of a vector (k = N_OUT-1)
// BEHAVIOUR
//  - N_OUT = X_SIZE-F_SIZE+1. Sample n lands at x[n]; coefficient j lands at f[j].
//  - Reset values: s_ready_x=s_ready_f=0 during reset, 1 in the first cycle after.
//    m_valid_y=0, m_last_y=0, m_data_out_y=0. All counters reset to 0. State = LOAD.
//  - FSM states: LOAD -> COMPUTE -> DRAIN -> LOAD.
//  - LOAD:
//    - s_ready_x=1 until X_SIZE samples are accepted; s_ready_f=1 until F_SIZE coefficients are accepted.
//    - The two streams are independent and may complete in either order.
//    - Go to COMPUTE in the cycle after both memories are full.
//  - COMPUTE:
//    - s_ready_x=s_ready_f=0.
//    - Issue index k=0..N_OUT-1, one per advancing cycle.
//    - After issuing k=N_OUT-1, go to DRAIN.
//  - Pipeline: S1 registers the F_SIZE products; S2 registers the sum into the output register.
//    - Latency from issue of k to m_valid_y = 2 cycles with no stalls.
//  - Advance enable: adv = !m_valid_y | m_ready_y.
//    - When adv=0, issue counter, S1 and S2 hold.
//    - m_data_out_y and m_last_y are stable while m_valid_y & !m_ready_y.
//  - Throughput: 1 y per cycle when m_ready_y is held high. N_OUT outputs per vector, no gaps.
//  - DRAIN: wait until the pipeline is empty and the y with m_last_y is accepted.
//    - Then clear both load counters and go to LOAD. s_ready_x/f rise the next cycle.
//  - Arithmetic:
//    - Products are DWX+DWF signed.
//    - The sum is computed at ACC_SIZE+clog2(F_SIZE) bits, then reduced to ACC_SIZE (see CONFIGURATION).
//  - Memory writes are ignored outside LOAD. The X/F contents are overwritten each vector.
//  - Reset mid-operation: reset in any state returns to LOAD. In-flight pipeline data is dropped and m_valid_y=0.
// CONFIGURATION
//  CONV_SAT_EN undefined: result is truncated to ACC_SIZE LSBs (two's-complement wrap).
//  CONV_SAT_EN defined:   result is clamped to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
// STRUCTURE
//  - Package conv_pkg:
//    - typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} conv_state_t;
//    - function sat_trunc(): wide sum -> ACC_SIZE; wrap or clamp selected by CONV_SAT_EN.
//  - Sub-module conv_load_ctrl (instantiated twice, for X and F):
//    - Parametrised by SIZE.
//    - Owns the write counter, full flag, s_ready and wr_en.
//    - clear input, driven on DRAIN exit.
//  - Top level holds the FSM, issue counter, X/F register arrays, S1/S2 pipeline and output register.
// TESTING
//  1. Default params, X=1..8, F=1,1,1,1, m_ready_y=1 -> y=10,14,18,22,26 on 5 consecutive cycles.
//     m_last_y high on 26; s_ready_x high again 1 cycle after that acceptance.
//  2. X=1..8, F=1,-1,0,2, m_ready_y toggling 1010.. -> y=7,9,11,13,15.
//     Each y held stable while !m_ready_y; no y lost or duplicated.
//  3. F fully loaded before X, and the reverse -> identical y; no COMPUTE until both memories are full.
//  4. ACC_SIZE=16, X all -128, F all -128 (sum 65536):
//     without CONV_SAT_EN y=0 x5; with it y=32767 x5.
//  5. Reset asserted during COMPUTE after 2 y accepted -> next cycle m_valid_y=0.
//     Then reload X=1..8, F=1,1,1,1 -> y=10,14,18,22,26.
//  6. Two back-to-back vectors with m_ready_y=1 -> 10 outputs total.
//     Exactly two m_last_y pulses; the second vector's data does not corrupt the first.

Source files
------------

// File: rtl/conv_pipe_mac_pkg.sv
// conv_pkg: shared types and helpers for the conv_pipe_mac slice.
//   conv_state_t : controller state (LOAD -> COMPUTE -> DRAIN -> LOAD)
//   sat_trunc()  : reduces a wide signed sum to acc_size bits.
// Build option: CONV_SAT_EN
//   undefined -> two's-complement wrap (keep the acc_size LSBs)
//   defined   -> clamp to [-2^(acc_size-1), 2^(acc_size-1)-1]
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } conv_state_t;

  // The result is returned sign-extended in 64 bits; callers keep the low
  // acc_size bits. acc_size must be in 2..63.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] sum,
                                                   input int acc_size);
    logic signed [63:0] r;
`ifdef CONV_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (acc_size - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sum > hi)      r = hi;
    else if (sum < lo) r = lo;
    else               r = sum;
`else
    // Shift the kept field to the top, then arithmetic-shift back down so
    // the value reads as the wrapped acc_size-bit result.
    r = (sum <<< (64 - acc_size)) >>> (64 - acc_size);
`endif
    return r;
  endfunction

endpackage

// File: rtl/conv_pipe_mac_if.sv
// conv_pipe_mac_if: X/F load streams and Y result stream of conv_pipe_mac.
//   slave  modport : the convolver side (accepts X/F, produces Y)
//   master modport : the stream masters / Y consumer side
// Handshake: every stream is valid/ready. A transfer happens on a rising clk
// edge where valid and ready are both high. A master holding valid keeps its
// data stable until that transfer; ready may change freely.
interface conv_pipe_mac_if #(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int ACC_SIZE     = 18
);
  logic                    s_valid_x;
  logic                    s_ready_x;
  logic [DATA_WIDTH_X-1:0] s_data_in_x;
  logic                    s_valid_f;
  logic                    s_ready_f;
  logic [DATA_WIDTH_F-1:0] s_data_in_f;
  logic                    m_valid_y;
  logic                    m_ready_y;
  logic [ACC_SIZE-1:0]     m_data_out_y;
  logic                    m_last_y;

  modport slave (
    input  s_valid_x, s_data_in_x, s_valid_f, s_data_in_f, m_ready_y,
    output s_ready_x, s_ready_f, m_valid_y, m_data_out_y, m_last_y
  );

  modport master (
    output s_valid_x, s_data_in_x, s_valid_f, s_data_in_f, m_ready_y,
    input  s_ready_x, s_ready_f, m_valid_y, m_data_out_y, m_last_y
  );
endinterface

// File: rtl/conv_pipe_mac_load_ctrl.sv
// conv_load_ctrl: write-side control for one coefficient/sample memory.
//   clk, reset : clock, synchronous active-high reset
//   enable     : memory may be written (controller in LOAD)
//   clear      : restart the fill for the next vector
//   s_valid    : incoming stream valid
//   s_ready    : stream ready (low in reset, outside LOAD, or once full)
//   wr_en      : write strobe for the memory (accepted transfer)
//   wr_idx     : address of the element being written
//   full       : all SIZE elements have been written
module conv_load_ctrl #(
  parameter  int SIZE = 8,
  localparam int CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          wr_en,
  output logic [CW-1:0] wr_idx,
  output logic          full
);
  logic [CW-1:0] cnt;

  // Gated by reset directly so ready is low while reset is held and high in
  // the very first cycle after it drops.
  assign s_ready = enable & ~full & ~reset;
  assign wr_en   = s_valid & s_ready;
  assign wr_idx  = cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      if (cnt == CW'(SIZE - 1)) full <= 1'b1;
      else                      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/conv_pipe_mac.sv
// conv_pipe_mac: pipelined 1-D valid convolution y[k] = sum_j x[k+j]*f[j].
//   clk, reset : clock, synchronous active-high reset
//   bus        : conv_pipe_mac_if.slave (X/F load streams, Y result stream)
//   state_dbg  : current controller state
// X and F are loaded in LOAD (either order), then COMPUTE issues one output
// index per advancing cycle into a 2-stage pipeline (S1 products, S2 sum),
// DRAIN waits for the final y to be taken and re-arms the loaders.
// Build option: CONV_SAT_EN selects saturation instead of wrap of the sum.
module conv_pipe_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 8,
  parameter int F_SIZE       = 4,
  parameter int ACC_SIZE     = 18
) (
  input  logic             clk,
  input  logic             reset,
  conv_pipe_mac_if.slave   bus,
  output conv_state_t      state_dbg
);
  localparam int N_OUT = X_SIZE - F_SIZE + 1;
  localparam int PW    = DATA_WIDTH_X + DATA_WIDTH_F;
  localparam int SUM_W = ACC_SIZE + $clog2(F_SIZE);
  localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int XW    = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int FW    = (F_SIZE > 1) ? $clog2(F_SIZE) : 1;

  conv_state_t state, state_next;
  logic        clear;

  logic          x_wr, x_full, f_wr, f_full;
  logic [XW-1:0] x_idx;
  logic [FW-1:0] f_idx;

  logic signed [DATA_WIDTH_X-1:0] x_mem [X_SIZE];
  logic signed [DATA_WIDTH_F-1:0] f_mem [F_SIZE];
  logic signed [PW-1:0]           prod  [F_SIZE];
  logic signed [SUM_W-1:0]        sum;
  logic                           s1_valid, s1_last;
  logic [IW-1:0]                  idx;
  logic                           adv, issue, last_issue;

  conv_load_ctrl #(.SIZE(X_SIZE)) u_load_x (
    .clk(clk), .reset(reset), .enable(state == LOAD), .clear(clear),
    .s_valid(bus.s_valid_x), .s_ready(bus.s_ready_x),
    .wr_en(x_wr), .wr_idx(x_idx), .full(x_full)
  );

  conv_load_ctrl #(.SIZE(F_SIZE)) u_load_f (
    .clk(clk), .reset(reset), .enable(state == LOAD), .clear(clear),
    .s_valid(bus.s_valid_f), .s_ready(bus.s_ready_f),
    .wr_en(f_wr), .wr_idx(f_idx), .full(f_full)
  );

  // The whole pipeline (issue counter, S1, S2) moves only when the output
  // register is empty or being taken, so a stalled y stays put.
  assign adv        = ~bus.m_valid_y | bus.m_ready_y;
  assign issue      = (state == COMPUTE) & adv;
  assign last_issue = (idx == IW'(N_OUT - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    case (state)
      LOAD:    if (x_full && f_full) state_next = COMPUTE;
      COMPUTE: if (issue && last_issue) state_next = DRAIN;
      DRAIN: begin
        if (bus.m_valid_y && bus.m_ready_y && bus.m_last_y) begin
          state_next = LOAD;
          clear      = 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_wr) x_mem[x_idx] <= bus.s_data_in_x;
    if (f_wr) f_mem[f_idx] <= bus.s_data_in_f;
  end

  always_ff @(posedge clk) begin
    if (reset)      idx <= '0;
    else if (issue) idx <= last_issue ? '0 : idx + 1'b1;
  end

  // S1: all F_SIZE products of the issued window in parallel.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= issue;
      s1_last  <= issue & last_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      for (int j = 0; j < F_SIZE; j++)
        prod[j] <= PW'(x_mem[int'(idx) + j]) * PW'(f_mem[j]);
    end
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < F_SIZE; j++) sum = sum + SUM_W'(prod[j]);
  end

  // S2: reduced sum into the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m_valid_y    <= 1'b0;
      bus.m_last_y     <= 1'b0;
      bus.m_data_out_y <= '0;
    end else if (adv) begin
      bus.m_valid_y <= s1_valid;
      bus.m_last_y  <= s1_valid & s1_last;
      if (s1_valid) bus.m_data_out_y <= ACC_SIZE'(sat_trunc(64'(sum), ACC_SIZE));
    end
  end
endmodule

// File: tb/tb_conv_pipe_mac.sv
// tb_conv_pipe_mac: scoreboard bench for conv_pipe_mac (ACC_SIZE=16 so the
// overflow case wraps/saturates). Inputs change 1 time unit after the rising
// edge; the monitor samples on the falling edge.
module tb_conv_pipe_mac;
  import conv_pkg::*;

  localparam int DWX = 8;
  localparam int DWF = 8;
  localparam int XS  = 8;
  localparam int FS  = 4;
  localparam int ACC = 16;
  localparam int NO  = XS - FS + 1;

  typedef int xvec_t [XS];
  typedef int fvec_t [FS];

  logic        clk = 1'b0;
  logic        reset;
  conv_state_t state_dbg;

  always #5 clk = ~clk;

  conv_pipe_mac_if #(.DATA_WIDTH_X(DWX), .DATA_WIDTH_F(DWF), .ACC_SIZE(ACC)) bus ();

  conv_pipe_mac #(
    .DATA_WIDTH_X(DWX), .DATA_WIDTH_F(DWF), .X_SIZE(XS), .F_SIZE(FS), .ACC_SIZE(ACC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [ACC:0] exp_q[$];     // {last, y}
  int acc_cyc[$];
  int acc_cnt = 0;
  int last_cnt = 0;
  int cyc = 0;
  int ready_mode = 0;         // 0: always ready, 1: toggle, 2: random
  bit stall_pend = 1'b0;
  bit chk_ready_next = 1'b0;
  logic [ACC-1:0] held_d;
  logic held_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired (t=%0t)", name, $time);
  endtask

  // Reference: direct sum of products, then wrap or clamp to ACC bits.
  function automatic logic [ACC-1:0] ref_y(input xvec_t xs, input fvec_t fs, input int k);
    longint s = 0;
    longint hi = (longint'(1) << (ACC - 1)) - 1;
    for (int j = 0; j < FS; j++) s += longint'(xs[k + j]) * longint'(fs[j]);
`ifdef CONV_SAT_EN
    if (s > hi) s = hi;
    else if (s < -hi - 1) s = -hi - 1;
`else
    if (hi < 0) s = 0;
`endif
    return ACC'(s);
  endfunction

  // Y ready driver.
  initial bus.m_ready_y = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.m_ready_y = 1'b1;
      1:       bus.m_ready_y = ~bus.m_ready_y;
      default: bus.m_ready_y = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      stall_pend     = 1'b0;
      chk_ready_next = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", bus.m_valid_y, 1'b1);
        check("stall_hold", {bus.m_last_y, bus.m_data_out_y}, {held_l, held_d});
      end
      if (chk_ready_next) begin
        check("ready_x_after_last", bus.s_ready_x, 1'b1);
        chk_ready_next = 1'b0;
      end
      if (bus.m_valid_y && bus.m_ready_y) begin
        if (exp_q.size() == 0) begin
          check("unexpected_y", {bus.m_last_y, bus.m_data_out_y}, '1);
        end else begin
          logic [ACC:0] e;
          e = exp_q.pop_front();
          check("y_data", {bus.m_last_y, bus.m_data_out_y}, e);
        end
        acc_cnt++;
        acc_cyc.push_back(cyc);
        if (bus.m_last_y) begin
          last_cnt++;
          chk_ready_next = 1'b1;
        end
      end
      stall_pend = bus.m_valid_y && !bus.m_ready_y;
      held_d     = bus.m_data_out_y;
      held_l     = bus.m_last_y;
    end
  end

  task automatic load_x(input xvec_t xs);
    @(posedge clk); #1;
    for (int i = 0; i < XS; i++) begin
      int n = 0;
      bus.s_valid_x   = 1'b1;
      bus.s_data_in_x = DWX'(xs[i]);
      forever begin
        @(negedge clk);
        if (bus.s_ready_x) break;
        n++;
        if (n > 400) begin
          timeout_fail("load_x");
          bus.s_valid_x = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        bus.s_valid_x = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_valid_x = 1'b0;
  endtask

  task automatic load_f(input fvec_t fs);
    @(posedge clk); #1;
    for (int i = 0; i < FS; i++) begin
      int n = 0;
      bus.s_valid_f   = 1'b1;
      bus.s_data_in_f = DWF'(fs[i]);
      forever begin
        @(negedge clk);
        if (bus.s_ready_f) break;
        n++;
        if (n > 400) begin
          timeout_fail("load_f");
          bus.s_valid_f = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        bus.s_valid_f = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.s_valid_f = 1'b0;
  endtask

  // order 0: both streams together, 1: F first, 2: X first.
  task automatic run_vector(input xvec_t xs, input fvec_t fs, input int order);
    for (int k = 0; k < NO; k++) exp_q.push_back({k == NO - 1, ref_y(xs, fs, k)});
    case (order)
      0: fork
           load_x(xs);
           load_f(fs);
         join
      1: begin
           load_f(fs);
           repeat (3) @(negedge clk);
           check("wait_for_x_state", state_dbg, LOAD);
           check("wait_for_x_no_y", bus.m_valid_y, 1'b0);
           load_x(xs);
         end
      default: begin
           load_x(xs);
           repeat (3) @(negedge clk);
           check("wait_for_f_state", state_dbg, LOAD);
           load_f(fs);
         end
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("drain");
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic xvec_t rand_x();
    xvec_t v;
    for (int i = 0; i < XS; i++) v[i] = int'($urandom_range(0, 255)) - 128;
    return v;
  endfunction

  function automatic fvec_t rand_f();
    fvec_t v;
    for (int i = 0; i < FS; i++) v[i] = int'($urandom_range(0, 255)) - 128;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    xvec_t x_ramp, x_neg, xr;
    fvec_t f_ones, f_mix, f_neg, fr;
    int base_acc, base_last, n;

    x_ramp = '{1, 2, 3, 4, 5, 6, 7, 8};
    f_ones = '{1, 1, 1, 1};
    f_mix  = '{1, -1, 0, 2};
    x_neg  = '{-128, -128, -128, -128, -128, -128, -128, -128};
    f_neg  = '{-128, -128, -128, -128};

    reset           = 1'b1;
    bus.s_valid_x   = 1'b0;
    bus.s_data_in_x = '0;
    bus.s_valid_f   = 1'b0;
    bus.s_data_in_f = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_x", bus.s_ready_x, 1'b0);
    check("rst_ready_f", bus.s_ready_f, 1'b0);
    check("rst_valid_y", bus.m_valid_y, 1'b0);
    check("rst_last_y", bus.m_last_y, 1'b0);
    check("rst_data_y", bus.m_data_out_y, '0);
    check("rst_state", state_dbg, LOAD);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready_x", bus.s_ready_x, 1'b1);
    check("post_rst_ready_f", bus.s_ready_f, 1'b1);

    // Ramp with unit filter, consumer always ready: back-to-back outputs.
    ready_mode = 0;
    acc_cyc.delete();
    run_vector(x_ramp, f_ones, 0);
    wait_idle();
    check("t1_count", acc_cyc.size(), 5);
    if (acc_cyc.size() == 5) check("t1_no_gaps", acc_cyc[4] - acc_cyc[0], 4);

    // Mixed-sign filter under toggling back-pressure.
    ready_mode = 1;
    run_vector(x_ramp, f_mix, 0);
    wait_idle();

    // Load order independence, random data and random back-pressure.
    ready_mode = 2;
    xr = rand_x();
    fr = rand_f();
    run_vector(xr, fr, 1);
    wait_idle();
    run_vector(xr, fr, 2);
    wait_idle();

    // Overflow: every y is 65536 before reduction.
    ready_mode = 0;
    run_vector(x_neg, f_neg, 0);
    wait_idle();

    // Reset after two outputs have been taken.
    base_acc = acc_cnt;
    run_vector(x_ramp, f_ones, 0);
    n = 0;
    while (acc_cnt < base_acc + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt < base_acc + 2) timeout_fail("reset_wait_two_y");
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid_y", bus.m_valid_y, 1'b0);
    check("midrst_ready_x", bus.s_ready_x, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_after_ready_x", bus.s_ready_x, 1'b1);
    check("midrst_after_state", state_dbg, LOAD);
    run_vector(x_ramp, f_ones, 0);
    wait_idle();

    // Two vectors back to back.
    base_acc  = acc_cnt;
    base_last = last_cnt;
    run_vector(x_ramp, f_ones, 0);
    run_vector(rand_x(), rand_f(), 0);
    wait_idle();
    check("b2b_outputs", acc_cnt - base_acc, 10);
    check("b2b_lasts", last_cnt - base_last, 2);

    // Random soak.
    ready_mode = 2;
    for (int v = 0; v < 4; v++) begin
      run_vector(rand_x(), rand_f(), int'($urandom_range(0, 2)));
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
